// File: rtl/mul_div_unit_pkg.sv
// mul_div_unit_pkg: shared MDop bit indices, FSM states and sizing for the mul/div unit.
package mul_div_unit_pkg;
    localparam int MD_WIDTH     = 32;
    localparam int MD_DIV_ITERS = 32;

    localparam int MD_DIV   = 7;
    localparam int MD_DIVU  = 6;
    localparam int MD_MULT  = 5;
    localparam int MD_MULTU = 4;
    localparam int MD_MFHI  = 3;
    localparam int MD_MFLO  = 2;
    localparam int MD_MTHI  = 1;
    localparam int MD_MTLO  = 0;

    typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} md_state_t;

    function automatic logic is_onehot(input logic [7:0] op);
        return (op != 8'd0) && ((op & (op - 8'd1)) == 8'd0);
    endfunction
endpackage

// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: decoder-to-mul/div handshake bundle.
interface mul_div_unit_if
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
);
    logic             md_valid;
    logic [7:0]       MDop;
    logic [WIDTH-1:0] md_rs;
    logic [WIDTH-1:0] md_rt;
    logic             md_cancel;
    logic             md_stall;
    logic [WIDTH-1:0] md_result;
    logic             md_done;

    modport master (
        output md_valid, MDop, md_rs, md_rt, md_cancel,
        input  md_stall, md_result, md_done
    );

    modport slave (
        input  md_valid, MDop, md_rs, md_rt, md_cancel,
        output md_stall, md_result, md_done
    );
endinterface

// File: rtl/mul_div_unit_divider.sv
// md_divider: iterative restoring divider on magnitudes with sign/zero fix-up on the outputs.
module md_divider
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH     = MD_WIDTH,
    parameter int DIV_ITERS = MD_DIV_ITERS
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             abort,
    input  logic             step,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             last,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);
    localparam int CW = $clog2(DIV_ITERS) + 1;

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] quo, rem, dvs, raw_a;
    logic             neg_q, neg_r, by_zero;
    logic [WIDTH:0]   diff;

    // quo starts as the dividend and shifts its bits into rem as quotient bits shift in
    assign diff      = {rem, quo[WIDTH-1]} - {1'b0, dvs};
    assign last      = cnt == CW'(DIV_ITERS - 1);
    assign quotient  = by_zero ? '1 : neg_q ? -quo : quo;
    assign remainder = by_zero ? raw_a : neg_r ? -rem : rem;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt     <= '0;
            quo     <= '0;
            rem     <= '0;
            dvs     <= '0;
            raw_a   <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            by_zero <= 1'b0;
        end else if (start) begin
            cnt     <= '0;
            quo     <= (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
            dvs     <= (is_signed && divisor[WIDTH-1]) ? -divisor : divisor;
            rem     <= '0;
            raw_a   <= dividend;
            neg_q   <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_r   <= is_signed && dividend[WIDTH-1];
            by_zero <= divisor == '0;
        end else if (abort) begin
            cnt <= '0;
        end else if (step) begin
            rem <= diff[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : diff[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
            cnt <= cnt + CW'(1);
        end
    end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: HI/LO owner, MDop front-end FSM, 1-cycle multiplier and iterative divider.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH     = MD_WIDTH,
    parameter int DIV_ITERS = MD_DIV_ITERS
) (
    input  logic           clk,
    input  logic           resetn,
    mul_div_unit_if.slave  md
);
    md_state_t          state, state_nxt;
    logic [WIDTH-1:0]   hi, lo, mul_a, mul_b, quo, rem;
    logic               mul_signed, accept, div_op, mul_op, last;
    logic [2*WIDTH-1:0] product;

    assign accept = md.md_valid && state == ST_IDLE && !md.md_cancel && is_onehot(md.MDop);
    assign div_op = md.MDop[MD_DIV] | md.MDop[MD_DIVU];
    assign mul_op = md.MDop[MD_MULT] | md.MDop[MD_MULTU];

    // sign- or zero-extend both operands to 64 bits so one multiply serves mult and multu
    assign product = {{WIDTH{mul_signed & mul_a[WIDTH-1]}}, mul_a}
                   * {{WIDTH{mul_signed & mul_b[WIDTH-1]}}, mul_b};

    assign md.md_stall  = state != ST_IDLE;
    assign md.md_done   = !md.md_cancel && (state == ST_MUL || state == ST_FIX);
    assign md.md_result = md.MDop[MD_MFHI] ? hi : lo;

    md_divider #(.WIDTH(WIDTH), .DIV_ITERS(DIV_ITERS)) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .start     (accept && div_op),
        .abort     (md.md_cancel),
        .step      (state == ST_DIV),
        .is_signed (md.MDop[MD_DIV]),
        .dividend  (md.md_rs),
        .divisor   (md.md_rt),
        .last      (last),
        .quotient  (quo),
        .remainder (rem)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: state_nxt = !accept ? ST_IDLE : div_op ? ST_DIV : mul_op ? ST_MUL : ST_IDLE;
            ST_DIV:  state_nxt = md.md_cancel ? ST_IDLE : last ? ST_FIX : ST_DIV;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi         <= '0;
            lo         <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            mul_signed <= 1'b0;
        end else begin
            if (accept && md.MDop[MD_MTHI]) hi <= md.md_rs;
            if (accept && md.MDop[MD_MTLO]) lo <= md.md_rs;
            if (accept && mul_op) begin
                mul_a      <= md.md_rs;
                mul_b      <= md.md_rt;
                mul_signed <= md.MDop[MD_MULT];
            end
            if (md.md_done && state == ST_MUL) {hi, lo} <= product;
            if (md.md_done && state == ST_FIX) begin
                hi <= rem;
                lo <= quo;
            end
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed and randomized checks of mul_div_unit against an arithmetic model.
module tb_mul_div_unit;
    localparam logic [7:0] OP_DIV = 8'h80, OP_DIVU = 8'h40, OP_MULT = 8'h20, OP_MULTU = 8'h10;
    localparam logic [7:0] OP_MFHI = 8'h08, OP_MFLO = 8'h04, OP_MTHI = 8'h02, OP_MTLO = 8'h01;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] m_hi = '0, m_lo = '0;

    mul_div_unit_if bus ();
    mul_div_unit dut (.clk(clk), .resetn(resetn), .md(bus));

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Reference: plain arithmetic on the architectural operation, plus expected stall length.
    task automatic model(input logic [7:0] op, input logic [31:0] rs, input logic [31:0] rt, output int stalls);
        logic [63:0] p;
        stalls = 0;
        case (op)
            OP_MULT: begin
                p = longint'($signed(rs)) * longint'($signed(rt));
                {m_hi, m_lo} = p;
                stalls = 1;
            end
            OP_MULTU: begin
                p = {32'd0, rs} * {32'd0, rt};
                {m_hi, m_lo} = p;
                stalls = 1;
            end
            OP_DIV: begin
                if (rt == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = rs; end
                else if (rs == 32'h8000_0000 && rt == 32'hFFFF_FFFF) begin m_lo = 32'h8000_0000; m_hi = 0; end
                else begin m_lo = 32'($signed(rs) / $signed(rt)); m_hi = 32'($signed(rs) % $signed(rt)); end
                stalls = 33;
            end
            OP_DIVU: begin
                if (rt == 0) begin m_lo = 32'hFFFF_FFFF; m_hi = rs; end
                else begin m_lo = rs / rt; m_hi = rs % rt; end
                stalls = 33;
            end
            OP_MTHI: m_hi = rs;
            OP_MTLO: m_lo = rs;
            default: stalls = 0;
        endcase
    endtask

    task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
        bus.MDop = OP_MFHI;
        #1 hi = bus.md_result;
        bus.MDop = OP_MFLO;
        #1 lo = bus.md_result;
        bus.MDop = 8'h00;
    endtask

    // Drives one instruction, measures stall/done timing, then reads HI/LO back via mfhi/mflo.
    task automatic run_op(input logic [7:0] op, input logic [31:0] rs, input logic [31:0] rt,
                          output int stalls, output int dones, output int done_at,
                          output logic [31:0] hi, output logic [31:0] lo);
        @(negedge clk);
        bus.md_valid = 1'b1; bus.MDop = op; bus.md_rs = rs; bus.md_rt = rt;
        @(negedge clk);
        bus.md_valid = 1'b0; bus.MDop = 8'h00;
        stalls = 0; dones = 0; done_at = 0;
        while (bus.md_stall && stalls < 100) begin
            stalls++;
            if (bus.md_done) begin dones++; done_at = stalls; end
            @(negedge clk);
        end
        read_hilo(hi, lo);
    endtask

    task automatic test_reset;
        bus.md_valid = 0; bus.MDop = 0; bus.md_rs = 0; bus.md_rt = 0; bus.md_cancel = 0;
        resetn = 1'b0;
        @(negedge clk); @(negedge clk);
        n_checks++; if (bus.md_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.md_stall); end
        n_checks++; if (bus.md_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.md_done); end
        n_checks++; if (bus.md_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", bus.md_result); end
        resetn = 1'b1;
        m_hi = 0; m_lo = 0;
    endtask

    task automatic test_mtlo_mflo;
        int s, d, da, es;
        logic [31:0] hi, lo;
        run_op(OP_MTLO, 32'h1234_5678, 32'h0, s, d, da, hi, lo);
        model(OP_MTLO, 32'h1234_5678, 32'h0, es);
        n_checks++; if (s !== 0) begin n_fail++; $display("FAIL mtlo_stall: got %0d cycles want 0", s); end
        n_checks++; if (lo !== 32'h1234_5678) begin n_fail++; $display("FAIL mflo_value: got %h want 12345678", lo); end
        run_op(OP_MTHI, 32'hA5A5_0F0F, 32'h0, s, d, da, hi, lo);
        model(OP_MTHI, 32'hA5A5_0F0F, 32'h0, es);
        n_checks++; if (hi !== 32'hA5A5_0F0F || s !== 0) begin n_fail++; $display("FAIL mthi: got %h/%0d want a5a50f0f/0", hi, s); end
    endtask

    task automatic test_mult;
        int s, d, da, es;
        logic [31:0] hi, lo;
        run_op(OP_MULT, 32'hFFFF_FFFF, 32'd2, s, d, da, hi, lo);
        model(OP_MULT, 32'hFFFF_FFFF, 32'd2, es);
        n_checks++; if (s !== 1 || d !== 1 || da !== 1) begin n_fail++; $display("FAIL mult_timing: got stall=%0d done=%0d@%0d want 1/1@1", s, d, da); end
        n_checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL mult_value: got %h_%h want ffffffff_fffffffe", hi, lo); end
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'd2, s, d, da, hi, lo);
        model(OP_MULTU, 32'hFFFF_FFFF, 32'd2, es);
        n_checks++; if (hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_value: got %h_%h want 00000001_fffffffe", hi, lo); end
    endtask

    task automatic test_div;
        int s, d, da, es;
        logic [31:0] hi, lo;
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, s, d, da, hi, lo);
        model(OP_DIV, 32'hFFFF_FFF9, 32'd2, es);
        n_checks++; if (s !== 33 || d !== 1 || da !== 33) begin n_fail++; $display("FAIL div_timing: got stall=%0d done=%0d@%0d want 33/1@33", s, d, da); end
        n_checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_value: got lo=%h hi=%h want fffffffd/ffffffff", lo, hi); end
        run_op(OP_DIVU, 32'd100, 32'd7, s, d, da, hi, lo);
        model(OP_DIVU, 32'd100, 32'd7, es);
        n_checks++; if (lo !== 32'd14 || hi !== 32'd2) begin n_fail++; $display("FAIL divu_value: got lo=%0d hi=%0d want 14/2", lo, hi); end
    endtask

    task automatic test_div_special;
        int s, d, da, es;
        logic [31:0] hi, lo;
        run_op(OP_DIVU, 32'hDEAD_BEEF, 32'd0, s, d, da, hi, lo);
        model(OP_DIVU, 32'hDEAD_BEEF, 32'd0, es);
        n_checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'hDEAD_BEEF || s !== 33) begin n_fail++; $display("FAIL divu_by_zero: got lo=%h hi=%h stall=%0d want ffffffff/deadbeef/33", lo, hi, s); end
        run_op(OP_DIV, 32'h8000_0005, 32'd0, s, d, da, hi, lo);
        model(OP_DIV, 32'h8000_0005, 32'd0, es);
        n_checks++; if (lo !== 32'hFFFF_FFFF || hi !== 32'h8000_0005) begin n_fail++; $display("FAIL div_by_zero: got lo=%h hi=%h want ffffffff/80000005", lo, hi); end
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, s, d, da, hi, lo);
        model(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, es);
        n_checks++; if (lo !== 32'h8000_0000 || hi !== 32'h0) begin n_fail++; $display("FAIL div_overflow: got lo=%h hi=%h want 80000000/0", lo, hi); end
    endtask

    task automatic test_protocol_violation;
        int s, d, da;
        logic [31:0] hi, lo;
        run_op(8'hA0, 32'h1111_1111, 32'h3, s, d, da, hi, lo);
        n_checks++; if (s !== 0 || hi !== m_hi || lo !== m_lo) begin n_fail++; $display("FAIL non_onehot: got stall=%0d %h_%h want 0 %h_%h", s, hi, lo, m_hi, m_lo); end
        run_op(8'h00, 32'h2222_2222, 32'h3, s, d, da, hi, lo);
        n_checks++; if (s !== 0 || hi !== m_hi || lo !== m_lo) begin n_fail++; $display("FAIL zero_op: got stall=%0d %h_%h want 0 %h_%h", s, hi, lo, m_hi, m_lo); end
    endtask

    task automatic test_cancel;
        int done_seen = 0;
        logic stall10;
        logic [31:0] hi, lo;
        @(negedge clk);
        bus.md_valid = 1; bus.MDop = OP_DIV; bus.md_rs = 32'd12345; bus.md_rt = 32'd17;
        @(negedge clk);
        bus.md_valid = 0; bus.MDop = 0;
        repeat (9) begin
            if (bus.md_done) done_seen++;
            @(negedge clk);
        end
        stall10 = bus.md_stall;
        bus.md_cancel = 1;
        if (bus.md_done) done_seen++;
        @(negedge clk);
        bus.md_cancel = 0;
        n_checks++; if (stall10 !== 1'b1 || bus.md_stall !== 1'b0) begin n_fail++; $display("FAIL cancel_stall: got %b->%b want 1->0", stall10, bus.md_stall); end
        repeat (30) begin
            if (bus.md_done) done_seen++;
            @(negedge clk);
        end
        n_checks++; if (done_seen !== 0) begin n_fail++; $display("FAIL cancel_done: got %0d pulses want 0", done_seen); end
        read_hilo(hi, lo);
        n_checks++; if (hi !== m_hi || lo !== m_lo) begin n_fail++; $display("FAIL cancel_hilo: got %h_%h want %h_%h", hi, lo, m_hi, m_lo); end
        @(negedge clk);
        bus.md_valid = 1; bus.MDop = OP_MTHI; bus.md_rs = 32'hCAFE_F00D; bus.md_cancel = 1;
        @(negedge clk);
        bus.md_valid = 0; bus.MDop = 0; bus.md_cancel = 0;
        read_hilo(hi, lo);
        n_checks++; if (hi !== m_hi) begin n_fail++; $display("FAIL cancel_mthi: got %h want %h", hi, m_hi); end
    endtask

    task automatic test_reset_mid_div;
        int s, d, da, es;
        logic [31:0] hi, lo;
        @(negedge clk);
        bus.md_valid = 1; bus.MDop = OP_DIVU; bus.md_rs = 32'd999; bus.md_rt = 32'd4;
        @(negedge clk);
        bus.md_valid = 0; bus.MDop = 0;
        repeat (4) @(negedge clk);
        resetn = 0;
        #1;
        n_checks++; if (bus.md_stall !== 1'b0) begin n_fail++; $display("FAIL midreset_stall: got %b want 0", bus.md_stall); end
        read_hilo(hi, lo);
        m_hi = 0; m_lo = 0;
        n_checks++; if (hi !== 32'h0 || lo !== 32'h0) begin n_fail++; $display("FAIL midreset_hilo: got %h_%h want 0_0", hi, lo); end
        @(negedge clk);
        resetn = 1;
        run_op(OP_DIV, 32'd1000, 32'hFFFF_FFFD, s, d, da, hi, lo);
        model(OP_DIV, 32'd1000, 32'hFFFF_FFFD, es);
        n_checks++; if (s !== es || hi !== m_hi || lo !== m_lo) begin n_fail++; $display("FAIL post_reset_div: got %0d %h_%h want %0d %h_%h", s, hi, lo, es, m_hi, m_lo); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] ops [6] = '{OP_DIV, OP_DIVU, OP_MULT, OP_MULTU, OP_MTHI, OP_MTLO};
        int s, d, da, es;
        logic [7:0] op;
        logic [31:0] rs, rt, hi, lo;
        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 5)];
            rs = $urandom;
            case ($urandom_range(0, 7))
                0:       rt = 32'd0;
                1:       rt = $urandom_range(1, 15);
                2:       rt = 32'hFFFF_FFFF;
                default: rt = $urandom;
            endcase
            run_op(op, rs, rt, s, d, da, hi, lo);
            model(op, rs, rt, es);
            n_checks++;
            if (s !== es || d !== (es > 0 ? 1 : 0) || hi !== m_hi || lo !== m_lo) begin
                n_fail++;
                $display("FAIL random[%0d] op=%h rs=%h rt=%h: got stall=%0d done=%0d %h_%h want %0d %h_%h",
                         i, op, rs, rt, s, d, hi, lo, es, m_hi, m_lo);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mtlo_mflo();
        test_mult();
        test_div();
        test_div_special();
        test_protocol_violation();
        test_cancel();
        test_reset_mid_div();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
